// File: rtl/stack_pkg.sv
// Shared constants and FSM state type for the stack controller.
package stack_pkg;
  localparam int unsigned SP_W              = 8;
  localparam int unsigned STACK_DEPTH_DEF   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/stack_control.sv
// Stack controller: drives push/pop/scan strobes and address for an external memory_array.
// Optional sticky overflow/underflow flags are enabled with `define STACK_ERR_FLAG_EN.
module stack_control
  import stack_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_edge,
  input  logic            push_req,
  input  logic            pop_req,
  input  logic            scan_req,
  output logic            stack_push,
  output logic            stack_pop,
  output logic            stack_citajVise,
  output logic [SP_W-1:0] sp,
  output logic [SP_W-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic            dout_valid,
  output logic            ovf,
  output logic            unf
);

  localparam logic [SP_W-1:0] DEPTH_V = SP_W'(STACK_DEPTH);

  state_t          state, state_next;
  logic [SP_W-1:0] count_q, count_next;
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] idx_q;
  logic            cv_q;
  logic [1:0]      dv_q;
  logic            is_idle;
  logic            scan_start;

  assign is_idle    = (state == IDLE);
  assign full       = (count_q == DEPTH_V);
  assign empty      = (count_q == '0);
  assign busy       = (state == SCAN);
  // A scan request that starts a scan blocks push/pop in that same cycle.
  assign scan_start = is_idle & scan_req & ~empty;
  assign stack_push = is_idle & ~scan_start & push_req & ~full;
  assign stack_pop  = is_idle & ~scan_start & pop_req & ~empty & ~push_req;

  assign sp              = sp_q;
  assign count           = count_q;
  assign stack_citajVise = cv_q;
  assign dout_valid      = dv_q[1];

  always_comb begin
    count_next = count_q;
    if (stack_push)
      count_next = count_q + 1'b1;
    else if (stack_pop)
      count_next = count_q - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (scan_start) state_next = SCAN;
      SCAN: if (idx_q == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge)
      state <= IDLE;
    else
      state <= state_next;
  end

  // In SCAN, idx_q is the address placed on sp at the next edge; the strobe
  // leads the address by one cycle and drops when address 0 goes out.
  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      count_q <= '0;
      sp_q    <= '0;
      idx_q   <= '0;
      cv_q    <= 1'b0;
      dv_q    <= '0;
    end else begin
      count_q <= count_next;
      dv_q    <= {dv_q[0], stack_pop | cv_q};
      case (state)
        IDLE: begin
          sp_q <= count_next;
          cv_q <= scan_start;
          if (scan_start)
            idx_q <= count_q - 1'b1;
        end
        SCAN: begin
          sp_q <= idx_q;
          cv_q <= (idx_q != '0);
          if (idx_q != '0)
            idx_q <= idx_q - 1'b1;
        end
        default: begin
          sp_q <= count_q;
          cv_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_ERR_FLAG_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk or posedge rst_edge) begin
    if (rst_edge) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (is_idle & push_req & full)
        ovf_q <= 1'b1;
      if (is_idle & pop_req & empty)
        unf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_control.sv
// Directed self-checking bench for stack_control with a behavioural memory_array.
module tb_stack_control;
  import stack_pkg::*;

  logic            clk = 1'b0;
  logic            rst_edge;
  logic            push_req, pop_req, scan_req;
  logic            stack_push, stack_pop, stack_citajVise;
  logic [SP_W-1:0] sp, count;
  logic            full, empty, busy, dout_valid, ovf, unf;

  logic [7:0] din;
  logic [7:0] data_out;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef STACK_ERR_FLAG_EN
  logic exp_err = 1'b1;
`else
  logic exp_err = 1'b0;
`endif

  stack_control #(.STACK_DEPTH(16)) dut (
    .clk             (clk),
    .rst_edge        (rst_edge),
    .push_req        (push_req),
    .pop_req         (pop_req),
    .scan_req        (scan_req),
    .stack_push      (stack_push),
    .stack_pop       (stack_pop),
    .stack_citajVise (stack_citajVise),
    .sp              (sp),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .busy            (busy),
    .dout_valid      (dout_valid),
    .ovf             (ovf),
    .unf             (unf)
  );

  always #5 clk = ~clk;

  // Memory with synchronous write and registered read of mem[sp].
  always @(posedge clk) begin
    if (stack_push) mem[sp] <= din;
    data_out <= mem[sp];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] e_sp   [6];
    logic       e_busy [6];
    logic       e_cv   [6];
    logic       e_dv   [6];
    logic [7:0] e_dat  [6];
    logic [7:0] vals   [3];

    rst_edge = 1'b1;
    push_req = 1'b0; pop_req = 1'b0; scan_req = 1'b0; din = '0;
    step(); step();
    check("rst_count", count, 0);
    check("rst_sp", sp, 0);
    check("rst_empty", empty, 1);
    check("rst_busy", busy, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    rst_edge = 1'b0;
    step();

    // push 3, 5, 9
    vals = '{8'h3, 8'h5, 8'h9};
    for (int i = 0; i < 3; i++) begin
      push_req = 1'b1; din = vals[i];
      #1 check("push_strobe", stack_push, 1);
      step();
    end
    push_req = 1'b0;
    check("push3_count", count, 3);
    check("push3_sp", sp, 3);
    check("mem0", mem[0], 8'h3);
    check("mem1", mem[1], 8'h5);
    check("mem2", mem[2], 8'h9);

    // pop from count=3
    pop_req = 1'b1;
    #1 check("pop_strobe", stack_pop, 1);
    step();
    pop_req = 1'b0;
    check("pop_sp", sp, 2);
    check("pop_count", count, 2);
    check("pop_dv_n1", dout_valid, 0);
    step();
    check("pop_dv_n2", dout_valid, 1);
    check("pop_data", data_out, 8'h9);
    step();
    check("pop_dv_n3", dout_valid, 0);

    // push and pop together at count=2: push wins
    push_req = 1'b1; pop_req = 1'b1; din = 8'h9;
    #1 check("both_push", stack_push, 1);
    check("both_pop", stack_pop, 0);
    step();
    push_req = 1'b0; pop_req = 1'b0;
    check("both_count", count, 3);
    check("both_mem2", mem[2], 8'h9);

    // scan with count=3
    e_sp   = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd3};
    e_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_cv   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    e_dv   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e_dat  = '{8'h0, 8'h0, 8'h9, 8'h5, 8'h3, 8'h0};
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("scan_sp[%0d]", i), sp, e_sp[i]);
      check($sformatf("scan_busy[%0d]", i), busy, e_busy[i]);
      check($sformatf("scan_cv[%0d]", i), stack_citajVise, e_cv[i]);
      check($sformatf("scan_dv[%0d]", i), dout_valid, e_dv[i]);
      check($sformatf("scan_count[%0d]", i), count, 3);
      if (e_dv[i]) check($sformatf("scan_data[%0d]", i), data_out, e_dat[i]);
      if (i == 1) begin
        push_req = 1'b1;
        #1 check("scan_push_blocked", stack_push, 0);
      end else begin
        push_req = 1'b0;
      end
      step();
    end
    push_req = 1'b0;

    // drain to empty, then pop on empty
    pop_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("drain_count[%0d]", i), count, 2 - i);
    end
    #1 check("empty_pop_strobe", stack_pop, 0);
    step();
    pop_req = 1'b0;
    check("empty_pop_count", count, 0);
    check("empty_pop_sp", sp, 0);
    check("unf_flag", unf, exp_err);

    // fill to 16, then a 17th push
    for (int i = 0; i < 16; i++) begin
      push_req = 1'b1; din = 8'(i + 8'h10);
      step();
    end
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_ovf_before", ovf, 0);
    #1 check("full_push_strobe", stack_push, 0);
    step();
    push_req = 1'b0;
    check("full_count", count, 16);
    check("full_sp", sp, 16);
    check("ovf_flag", ovf, exp_err);

    // reset pulse mid-scan
    scan_req = 1'b1;
    step();
    scan_req = 1'b0;
    step(); step();
    check("midscan_busy", busy, 1);
    #2 rst_edge = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_count", count, 0);
    check("abort_sp", sp, 0);
    check("abort_cv", stack_citajVise, 0);
    check("abort_dv", dout_valid, 0);
    check("abort_ovf", ovf, 0);
    step();
    rst_edge = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_abort_dv[%0d]", i), dout_valid, 0);
    end
    check("post_abort_busy", busy, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
